// File: rtl/udp2srio_packer.sv
// Packs IN_WIDTH UDP beats into OUT_WIDTH SRIO beats, stores whole packets, and issues
// one NWRITE request with the measured byte length per complete packet.
module udp2srio_packer #(
   parameter int unsigned IN_WIDTH   = 32,
   parameter int unsigned OUT_WIDTH  = 64,
   parameter int unsigned FIFO_DEPTH = 256,
   parameter int unsigned PKT_DEPTH  = 16,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                    clk_srio,
   input  logic                    reset_srio_n,
   input  logic [IN_WIDTH-1:0]     udp_data_in,
   input  logic                    udp_valid_in,
   input  logic                    udp_first_in,
   input  logic [IN_WIDTH/8-1:0]   udp_keep_in,
   input  logic                    udp_last_in,
   output logic                    udp_ready_out,
   input  logic                    srio_ready_in,
   output logic                    nwr_req_out,
   output logic [LEN_WIDTH-1:0]    srio_length_out,
   output logic [OUT_WIDTH-1:0]    srio_data_out,
   output logic                    srio_valid_out,
   output logic                    srio_first_out,
   output logic [OUT_WIDTH/8-1:0]  srio_keep_out,
   output logic                    srio_last_out,
   output logic                    err_first_out,
   output logic                    err_ovf_out
);
   localparam int unsigned R      = OUT_WIDTH / IN_WIDTH;
   localparam int unsigned IN_B   = IN_WIDTH / 8;
   localparam int unsigned OUT_B  = OUT_WIDTH / 8;
   localparam int unsigned LANE_W = (R > 1) ? $clog2(R) : 1;
   localparam int unsigned DAW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PAW    = $clog2(PKT_DEPTH);
   localparam int unsigned ENT_W  = OUT_WIDTH + OUT_B + 1;

   typedef enum logic [0:0] {IDLE, DATA} state_t;
   state_t state, state_nx;

   logic                  accept_c, dpush_c, ppush_c, dpop_c, ppop_c;
   logic [LANE_W-1:0]     lane;
   logic                  in_pkt;
   logic [OUT_WIDTH-1:0]  pack_data, wr_data_c;
   logic [OUT_B-1:0]      pack_keep, wr_keep_c;
   logic [LEN_WIDTH-1:0]  acc, len_c;
   logic [LEN_WIDTH:0]    bytes_c, sum_c;

   logic [ENT_W-1:0]      dmem [FIFO_DEPTH];
   logic [LEN_WIDTH-1:0]  pmem [PKT_DEPTH];
   logic [DAW-1:0]        dwr, drd;
   logic [PAW-1:0]        pwr, prd;
   logic [DAW:0]          dcnt, dcnt_nx_c;
   logic [PAW:0]          pcnt, pcnt_nx_c;
   logic [OUT_WIDTH-1:0]  hd_data;
   logic [OUT_B-1:0]      hd_keep;
   logic                  hd_last;

   logic                  req_nx, valid_nx, first_nx, last_nx, pend_nx, done_nx;
   logic                  first_pend, loaded_last;
   logic [LEN_WIDTH-1:0]  len_nx;
   logic [OUT_WIDTH-1:0]  data_nx;
   logic [OUT_B-1:0]      keep_nx;

   // Lane merge and saturating byte count for the current input beat
   always_comb begin
      accept_c  = udp_valid_in & udp_ready_out;
      dpush_c   = accept_c & (udp_last_in | (lane == LANE_W'(R - 1)));
      ppush_c   = accept_c & udp_last_in;
      wr_data_c = pack_data;
      wr_keep_c = pack_keep;
      for (int unsigned k = 0; k < R; k++) begin
         if (lane == LANE_W'(k)) begin
            wr_data_c[OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] = udp_data_in;
            wr_keep_c[OUT_B-1-k*IN_B -: IN_B]             = udp_keep_in;
         end
      end
      bytes_c = '0;
      for (int unsigned i = 0; i < IN_B; i++) begin
         bytes_c = bytes_c + (LEN_WIDTH + 1)'(udp_keep_in[i]);
      end
      sum_c = (LEN_WIDTH + 1)'(acc) + bytes_c;
      len_c = sum_c[LEN_WIDTH] ? '1 : sum_c[LEN_WIDTH-1:0];
   end

   always_comb begin
      dcnt_nx_c = dcnt + (DAW + 1)'(dpush_c) - (DAW + 1)'(dpop_c);
      pcnt_nx_c = pcnt + (PAW + 1)'(ppush_c) - (PAW + 1)'(ppop_c);
      {hd_data, hd_keep, hd_last} = dmem[drd];
   end

   always_ff @(posedge clk_srio) begin
      if (!reset_srio_n) begin
         lane          <= '0;
         in_pkt        <= 1'b0;
         pack_data     <= '0;
         pack_keep     <= '0;
         acc           <= '0;
         err_first_out <= 1'b0;
         udp_ready_out <= 1'b0;
      end else begin
         err_first_out <= accept_c & (udp_first_in == in_pkt);
         // Ready from next-cycle levels; data side keeps one slot spare
         udp_ready_out <= (dcnt_nx_c < (DAW + 1)'(FIFO_DEPTH - 1)) &
                          (pcnt_nx_c != (PAW + 1)'(PKT_DEPTH));
         if (accept_c) begin
            in_pkt <= !udp_last_in;
            acc    <= udp_last_in ? '0 : len_c;
            if (dpush_c) begin
               lane      <= '0;
               pack_data <= '0;
               pack_keep <= '0;
            end else begin
               lane      <= lane + LANE_W'(1);
               pack_data <= wr_data_c;
               pack_keep <= wr_keep_c;
            end
         end
      end
   end

   always_ff @(posedge clk_srio) begin
      if (dpush_c) dmem[dwr] <= {wr_data_c, wr_keep_c, udp_last_in};
      if (ppush_c) pmem[pwr] <= len_c;
   end

   always_ff @(posedge clk_srio) begin
      if (!reset_srio_n) begin
         dwr         <= '0;
         drd         <= '0;
         dcnt        <= '0;
         pwr         <= '0;
         prd         <= '0;
         pcnt        <= '0;
         err_ovf_out <= 1'b0;
      end else begin
         if (dpush_c) dwr <= dwr + DAW'(1);
         if (dpop_c)  drd <= drd + DAW'(1);
         if (ppush_c) pwr <= pwr + PAW'(1);
         if (ppop_c)  prd <= prd + PAW'(1);
         dcnt        <= dcnt_nx_c;
         pcnt        <= pcnt_nx_c;
         err_ovf_out <= err_ovf_out |
                        ((dcnt >= (DAW + 1)'(FIFO_DEPTH - 1)) & (pcnt == '0));
      end
   end

   always_ff @(posedge clk_srio) begin
      if (!reset_srio_n) state <= IDLE;
      else               state <= state_nx;
   end

   // Output sequencing: request pulse, then drain one packet through the output register
   always_comb begin
      state_nx = state;
      req_nx   = 1'b0;
      len_nx   = srio_length_out;
      valid_nx = srio_valid_out;
      data_nx  = srio_data_out;
      keep_nx  = srio_keep_out;
      first_nx = srio_first_out;
      last_nx  = srio_last_out;
      pend_nx  = first_pend;
      done_nx  = loaded_last;
      ppop_c   = 1'b0;
      dpop_c   = 1'b0;
      case (state)
         IDLE: begin
            if (pcnt != '0) begin
               ppop_c   = 1'b1;
               req_nx   = 1'b1;
               len_nx   = pmem[prd];
               pend_nx  = 1'b1;
               done_nx  = 1'b0;
               state_nx = DATA;
            end
         end
         DATA: begin
            if (srio_valid_out & srio_ready_in) begin
               valid_nx = 1'b0;
               data_nx  = '0;
               keep_nx  = '0;
               first_nx = 1'b0;
               last_nx  = 1'b0;
               if (srio_last_out) state_nx = IDLE;
            end
            if (!loaded_last && (dcnt != '0) && (!srio_valid_out || srio_ready_in)) begin
               dpop_c   = 1'b1;
               valid_nx = 1'b1;
               data_nx  = hd_data;
               keep_nx  = hd_keep;
               last_nx  = hd_last;
               first_nx = first_pend;
               pend_nx  = 1'b0;
               done_nx  = hd_last;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_srio) begin
      if (!reset_srio_n) begin
         nwr_req_out     <= 1'b0;
         srio_length_out <= '0;
         srio_valid_out  <= 1'b0;
         srio_data_out   <= '0;
         srio_keep_out   <= '0;
         srio_first_out  <= 1'b0;
         srio_last_out   <= 1'b0;
         first_pend      <= 1'b0;
         loaded_last     <= 1'b0;
      end else begin
         nwr_req_out     <= req_nx;
         srio_length_out <= len_nx;
         srio_valid_out  <= valid_nx;
         srio_data_out   <= data_nx;
         srio_keep_out   <= keep_nx;
         srio_first_out  <= first_nx;
         srio_last_out   <= last_nx;
         first_pend      <= pend_nx;
         loaded_last     <= done_nx;
      end
   end
endmodule

// File: tb/tb_udp2srio_packer.sv
// Directed bench for udp2srio_packer: default instance plus a FIFO_DEPTH=8 instance for overflow.
module tb_udp2srio_packer;
   logic        clk = 1'b0;
   logic        reset_srio_n;
   logic [31:0] udp_data_in;
   logic        udp_valid_in, udp_first_in, udp_last_in, udp_ready_out;
   logic [3:0]  udp_keep_in;
   logic        srio_ready_in, nwr_req_out, srio_valid_out, srio_first_out, srio_last_out;
   logic [15:0] srio_length_out;
   logic [63:0] srio_data_out;
   logic [7:0]  srio_keep_out;
   logic        err_first_out, err_ovf_out;

   logic [31:0] s_data;
   logic        s_valid, s_first, s_last, s_ready, s_srdy, s_req, s_ovalid, s_ofirst, s_olast;
   logic [3:0]  s_keep;
   logic [15:0] s_len;
   logic [63:0] s_odata;
   logic [7:0]  s_okeep;
   logic        s_errf, s_erro;

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   int n;

   logic [15:0] req_len_q [$];
   int          req_cyc_q [$];
   logic [63:0] beat_d_q  [$];
   logic [9:0]  beat_c_q  [$];
   int          xfer_cyc_q[$];
   logic        stalled = 1'b0;
   logic [63:0] held_d;
   logic [9:0]  held_c;

   always #5 clk = ~clk;

   udp2srio_packer u_dut (
      .clk_srio(clk), .reset_srio_n(reset_srio_n),
      .udp_data_in(udp_data_in), .udp_valid_in(udp_valid_in), .udp_first_in(udp_first_in),
      .udp_keep_in(udp_keep_in), .udp_last_in(udp_last_in), .udp_ready_out(udp_ready_out),
      .srio_ready_in(srio_ready_in), .nwr_req_out(nwr_req_out), .srio_length_out(srio_length_out),
      .srio_data_out(srio_data_out), .srio_valid_out(srio_valid_out), .srio_first_out(srio_first_out),
      .srio_keep_out(srio_keep_out), .srio_last_out(srio_last_out),
      .err_first_out(err_first_out), .err_ovf_out(err_ovf_out)
   );

   udp2srio_packer #(.FIFO_DEPTH(8)) u_small (
      .clk_srio(clk), .reset_srio_n(reset_srio_n),
      .udp_data_in(s_data), .udp_valid_in(s_valid), .udp_first_in(s_first),
      .udp_keep_in(s_keep), .udp_last_in(s_last), .udp_ready_out(s_ready),
      .srio_ready_in(s_srdy), .nwr_req_out(s_req), .srio_length_out(s_len),
      .srio_data_out(s_odata), .srio_valid_out(s_ovalid), .srio_first_out(s_ofirst),
      .srio_keep_out(s_okeep), .srio_last_out(s_olast),
      .err_first_out(s_errf), .err_ovf_out(s_erro)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic f, input logic l);
      udp_data_in  = d;
      udp_keep_in  = k;
      udp_first_in = f;
      udp_last_in  = l;
      udp_valid_in = 1'b1;
      tick();
      udp_valid_in = 1'b0;
      udp_first_in = 1'b0;
      udp_last_in  = 1'b0;
   endtask

   task automatic clear_q();
      req_len_q.delete();
      req_cyc_q.delete();
      beat_d_q.delete();
      beat_c_q.delete();
      xfer_cyc_q.delete();
   endtask

   // Mid-cycle monitor: logs requests and transfers, checks outputs hold while stalled
   always @(negedge clk) begin
      cyc++;
      if (stalled) begin
         check("hold_data", srio_data_out, held_d);
         check("hold_ctl", {srio_valid_out, srio_keep_out, srio_first_out, srio_last_out},
               {1'b1, held_c[9:2], held_c[1], held_c[0]});
      end
      stalled = srio_valid_out && !srio_ready_in && reset_srio_n;
      held_d  = srio_data_out;
      held_c  = {srio_keep_out, srio_first_out, srio_last_out};
      if (nwr_req_out) begin
         req_len_q.push_back(srio_length_out);
         req_cyc_q.push_back(cyc);
      end
      if (srio_valid_out && srio_ready_in) begin
         beat_d_q.push_back(srio_data_out);
         beat_c_q.push_back({srio_keep_out, srio_first_out, srio_last_out});
         xfer_cyc_q.push_back(cyc);
      end
   end

   initial begin
      // Reset held with input valid
      reset_srio_n = 1'b0;
      udp_data_in = 32'hDEADBEEF; udp_keep_in = 4'hF; udp_first_in = 1'b1; udp_last_in = 1'b1;
      udp_valid_in = 1'b1; srio_ready_in = 1'b1;
      s_data = '0; s_keep = 4'hF; s_first = 1'b0; s_last = 1'b0; s_valid = 1'b0; s_srdy = 1'b1;
      repeat (5) tick();
      check("rst_outputs", {udp_ready_out, nwr_req_out, srio_length_out, srio_data_out, srio_valid_out,
            srio_first_out, srio_keep_out, srio_last_out, err_first_out, err_ovf_out}, '0);
      reset_srio_n = 1'b1;
      udp_valid_in = 1'b0; udp_first_in = 1'b0; udp_last_in = 1'b0;
      tick();
      check("rst_ready_after", udp_ready_out, 1'b1);
      repeat (4) tick();
      check("rst_no_req", req_len_q.size(), 0);
      check("rst_no_beats", beat_d_q.size(), 0);

      // Even packet with exact latency
      clear_q();
      send(32'h11111111, 4'hF, 1'b1, 1'b0);
      send(32'h22222222, 4'hF, 1'b0, 1'b0);
      send(32'h33333333, 4'hF, 1'b0, 1'b0);
      send(32'h44444444, 4'hF, 1'b0, 1'b1);
      check("even_req_t1", nwr_req_out, 1'b0);
      tick();
      check("even_req_t2", {nwr_req_out, srio_valid_out}, 2'b10);
      check("even_len", srio_length_out, 16'd16);
      tick();
      check("even_b0_data", srio_data_out, 64'h11111111_22222222);
      check("even_b0_ctl", {nwr_req_out, srio_valid_out, srio_keep_out, srio_first_out, srio_last_out},
            {2'b01, 8'hFF, 2'b10});
      tick();
      check("even_b1_data", srio_data_out, 64'h33333333_44444444);
      check("even_b1_ctl", {srio_valid_out, srio_keep_out, srio_first_out, srio_last_out},
            {1'b1, 8'hFF, 2'b01});
      tick();
      check("even_done", {srio_valid_out, srio_data_out, srio_keep_out}, '0);
      check("even_len_held", srio_length_out, 16'd16);
      repeat (3) tick();

      // Odd tail
      clear_q();
      send(32'hAAAAAAAA, 4'hF, 1'b1, 1'b0);
      send(32'hBBBBBBBB, 4'hF, 1'b0, 1'b0);
      send(32'hCCCC0000, 4'b1100, 1'b0, 1'b1);
      repeat (6) tick();
      check("odd_nreq", req_len_q.size(), 1);
      check("odd_len", req_len_q[0], 16'd10);
      check("odd_nbeats", beat_d_q.size(), 2);
      check("odd_b0", {beat_d_q[0], beat_c_q[0]}, {64'hAAAAAAAA_BBBBBBBB, 8'hFF, 2'b10});
      check("odd_b1", {beat_d_q[1], beat_c_q[1]}, {64'hCCCC0000_00000000, 8'hC0, 2'b01});

      // Backpressure with two queued packets
      clear_q();
      srio_ready_in = 1'b0;
      send(32'h10000001, 4'hF, 1'b1, 1'b0);
      send(32'h10000002, 4'hF, 1'b0, 1'b0);
      send(32'h10000003, 4'hF, 1'b0, 1'b0);
      send(32'h10000004, 4'hF, 1'b0, 1'b1);
      send(32'h20000001, 4'hF, 1'b1, 1'b0);
      send(32'h20000002, 4'hF, 1'b0, 1'b1);
      for (int c = 0; c < 40; c++) begin
         srio_ready_in = ~srio_ready_in;
         tick();
      end
      srio_ready_in = 1'b1;
      repeat (3) tick();
      check("bp_nreq", req_len_q.size(), 2);
      check("bp_len0", req_len_q[0], 16'd16);
      check("bp_len1", req_len_q[1], 16'd8);
      check("bp_nbeats", beat_d_q.size(), 3);
      check("bp_b0", {beat_d_q[0], beat_c_q[0]}, {64'h10000001_10000002, 8'hFF, 2'b10});
      check("bp_b1", {beat_d_q[1], beat_c_q[1]}, {64'h10000003_10000004, 8'hFF, 2'b01});
      check("bp_b2", {beat_d_q[2], beat_c_q[2]}, {64'h20000001_20000002, 8'hFF, 2'b11});
      check("bp_idle_gap", req_cyc_q[1] - xfer_cyc_q[1], 2);

      // Descriptor FIFO full with one-beat packets
      reset_srio_n = 1'b0;
      repeat (2) tick();
      reset_srio_n = 1'b1;
      tick();
      clear_q();
      srio_ready_in = 1'b0;
      udp_keep_in = 4'hF; udp_first_in = 1'b1; udp_last_in = 1'b1; udp_valid_in = 1'b1;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         udp_data_in = 32'(n);
         if (!udp_ready_out) break;
         tick();
         n++;
      end
      udp_valid_in = 1'b0; udp_first_in = 1'b0; udp_last_in = 1'b0;
      check("full_accepted", n, 17);
      check("full_ready_low", udp_ready_out, 1'b0);
      tick();
      check("full_ready_stays", udp_ready_out, 1'b0);
      srio_ready_in = 1'b1;
      tick();
      check("full_pop_cycle", {udp_ready_out, nwr_req_out}, 2'b00);
      tick();
      check("full_ready_back", {udp_ready_out, nwr_req_out}, 2'b11);
      repeat (120) tick();
      check("full_nbeats", beat_d_q.size(), 17);
      check("full_nreq", req_len_q.size(), 17);
      for (int i = 0; i < 17; i++) begin
         check("full_beat", {beat_d_q[i], beat_c_q[i]}, {32'(i), 32'h0, 8'hF0, 2'b11});
      end

      // Framing errors: first set mid-packet, then missing on a start beat
      clear_q();
      send(32'h00000001, 4'hF, 1'b1, 1'b0);
      check("errf_ok_start", err_first_out, 1'b0);
      send(32'h00000002, 4'hF, 1'b1, 1'b0);
      check("errf_mid_first", err_first_out, 1'b1);
      send(32'h00000003, 4'hF, 1'b0, 1'b1);
      check("errf_pulse_end", err_first_out, 1'b0);
      send(32'h00000004, 4'hF, 1'b0, 1'b1);
      check("errf_start_nofirst", err_first_out, 1'b1);
      tick();
      check("errf_one_cycle", err_first_out, 1'b0);
      repeat (10) tick();
      check("errf_nreq", req_len_q.size(), 2);
      check("errf_len0", req_len_q[0], 16'd12);
      check("errf_len1", req_len_q[1], 16'd4);
      check("errf_nbeats", beat_d_q.size(), 3);
      check("errf_b1", {beat_d_q[1], beat_c_q[1]}, {64'h00000003_00000000, 8'hF0, 2'b01});
      check("errf_b2", {beat_d_q[2], beat_c_q[2]}, {64'h00000004_00000000, 8'hF0, 2'b11});

      // Reset mid-packet discards the partial packet
      clear_q();
      send(32'h0000000A, 4'hF, 1'b1, 1'b0);
      send(32'h0000000B, 4'hF, 1'b0, 1'b0);
      reset_srio_n = 1'b0;
      repeat (2) tick();
      reset_srio_n = 1'b1;
      tick();
      check("midrst_ready", udp_ready_out, 1'b1);
      repeat (8) tick();
      check("midrst_no_req", req_len_q.size(), 0);
      check("midrst_no_beats", beat_d_q.size(), 0);
      send(32'h0000000C, 4'hF, 1'b1, 1'b1);
      check("midrst_start_ok", err_first_out, 1'b0);
      repeat (6) tick();
      check("midrst_nreq", req_len_q.size(), 1);
      check("midrst_len", req_len_q[0], 16'd4);
      check("midrst_beat", {beat_d_q[0], beat_c_q[0]}, {64'h0000000C_00000000, 8'hF0, 2'b11});

      // Oversize packet into the 8-deep instance
      s_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 30 && n < 20; c++) begin
         s_data  = 32'(n);
         s_first = (n == 0);
         s_last  = (n == 19);
         if (!s_ready) break;
         tick();
         n++;
      end
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
      check("ovf_accepted", n, 14);
      tick();
      check("ovf_flags", {s_erro, s_ready, s_req, s_ovalid}, 4'b1000);
      repeat (3) tick();
      check("ovf_sticky", {s_erro, s_ready}, 2'b10);
      reset_srio_n = 1'b0;
      repeat (2) tick();
      reset_srio_n = 1'b1;
      tick();
      check("ovf_cleared", {s_erro, s_ready}, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
